// File: rtl/truth_table_sweeper.sv
// Steps abcd through all 16 input combinations (prescaler or pushbutton) and records the
// selected function output into a 16-bit truth map. Optional golden checker: SWEEP_CHECK_EN.
module truth_table_sweeper #(
    parameter int PRESCALE    = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        auto_mode,
    input  logic        step_btn,
    input  logic [1:0]  func_sel,
    input  logic [2:0]  y_in,
    output logic [3:0]  abcd,
    output logic [15:0] capt_map,
    output logic        busy,
    output logic        done,
    output logic        err_flag,
    output logic [4:0]  err_cnt
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             abcd_q, abcd_d;
    logic [15:0]            capt_q, capt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [PW-1:0]          pre_q, pre_d;
    logic [1:0]             fs_q, fs_d;
    logic                   auto_q, auto_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   btn_rise;
    logic                   y_sel;

    assign btn_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

    always_comb begin
        state_d = state_q;
        abcd_d  = abcd_q;
        capt_d  = capt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pre_d   = pre_q;
        fs_d    = fs_q;
        auto_d  = auto_q;
        sync_d  = {sync_q[SYNC_STAGES-2:0], step_btn};
        prev_d  = sync_q[SYNC_STAGES-1];
        case (fs_q)
            2'd0:    y_sel = y_in[0];
            2'd1:    y_sel = y_in[1];
            2'd2:    y_sel = y_in[2];
            default: y_sel = 1'b0;
        endcase
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    fs_d    = func_sel;
                    auto_d  = auto_mode;
                    abcd_d  = 4'd0;
                    capt_d  = 16'd0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    pre_d   = '0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (auto_q) begin
                    if (pre_q == PRE_LAST) begin
                        pre_d   = '0;
                        state_d = SAMPLE;
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end else if (btn_rise) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                capt_d[abcd_q] = y_sel;
                if (abcd_q == 4'd15) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    abcd_d  = abcd_q + 4'd1;
                    state_d = APPLY;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            abcd_q  <= 4'd0;
            capt_q  <= 16'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pre_q   <= '0;
            fs_q    <= 2'd0;
            auto_q  <= 1'b0;
            sync_q  <= '0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            abcd_q  <= abcd_d;
            capt_q  <= capt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pre_q   <= pre_d;
            fs_q    <= fs_d;
            auto_q  <= auto_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
        end
    end

`ifdef SWEEP_CHECK_EN
    logic       err_flag_q, err_flag_d;
    logic [4:0] err_cnt_q, err_cnt_d;
    logic       gold, ga, gb, gc;
    logic       sample_en, clr_err;

    assign ga        = abcd_q[3];
    assign gb        = abcd_q[2];
    assign gc        = abcd_q[1];
    assign sample_en = (state_q == SAMPLE);
    assign clr_err   = ((state_q == IDLE) || (state_q == DONE)) && start;

    always_comb begin
        case (fs_q)
            2'd0:    gold = (~ga & ~gc) | (~gb & ~gc) | (ga & gc);
            2'd1:    gold = ~gb;
            2'd2:    gold = ~^abcd_q;
            default: gold = 1'b0;
        endcase
        err_flag_d = err_flag_q;
        err_cnt_d  = err_cnt_q;
        if (clr_err) begin
            err_flag_d = 1'b0;
            err_cnt_d  = 5'd0;
        end else if (sample_en && (y_sel != gold)) begin
            err_flag_d = 1'b1;
            // 16 vectors max, so the count saturates rather than wraps
            if (err_cnt_q != 5'd16) err_cnt_d = err_cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag_q <= 1'b0;
            err_cnt_q  <= 5'd0;
        end else begin
            err_flag_q <= err_flag_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
`else
    assign err_flag = 1'b0;
    assign err_cnt  = 5'd0;
`endif

    assign abcd     = abcd_q;
    assign capt_map = capt_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
